// File: rtl/byte_frame_analyser.sv
// UART receive-path byte analyser: checks parity/stop, writes good bytes to the byte FIFO and
// closes frames on baud-tick idle gaps. Define BFA_TIMESTAMP_EN to keep per-frame start stamps.
module byte_frame_analyser #(
  parameter int DATA_W      = 8,
  parameter int FRAME_DEPTH = 4,
  parameter int CNT_W       = 12,
  parameter int STAMP_W     = 16,
  parameter int GAP_BAUDS   = 28
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           byte_valid_i,
  input  logic [DATA_W-1:0]              data_i,
  input  logic                           parity_bit_i,
  input  logic                           stop_bit_i,
  input  logic                           baud_tick_i,
  input  logic [STAMP_W-1:0]             stamp_i,
  input  logic                           cfg_parity_en_i,
  input  logic                           cfg_parity_odd_i,
  input  logic                           cfg_msb_first_i,
  output logic                           n_we_o,
  output logic [DATA_W-1:0]              data_o,
  input  logic                           p_full_i,
  input  logic                           frame_rd_i,
  output logic                           frame_valid_o,
  output logic [STAMP_W+CNT_W-1:0]       frame_info_o,
  output logic [$clog2(FRAME_DEPTH):0]   frame_level_o,
  output logic [7:0]                     parity_err_cnt_o,
  output logic [7:0]                     stop_err_cnt_o,
  output logic [7:0]                     byte_drop_cnt_o,
  output logic [7:0]                     frame_drop_cnt_o
);

  localparam int PTR_W = $clog2(FRAME_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int REC_W = STAMP_W + CNT_W;
  localparam logic [7:0]       GAP_MAX  = 8'(GAP_BAUDS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FRAME_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_WRITE
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_lat_q, data_lat_d;
  logic                par_lat_q, par_lat_d;
  logic                stop_lat_q, stop_lat_d;
  logic                par_ok_q, par_ok_d;
  logic                stop_ok_q, stop_ok_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [7:0]          gap_q, gap_d;
  logic                frame_open_q, frame_open_d;
  logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic [REC_W-1:0]    mem_q [FRAME_DEPTH];
  logic [REC_W-1:0]    mem_d [FRAME_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [7:0]          perr_q, perr_d;
  logic [7:0]          serr_q, serr_d;
  logic [7:0]          bdrop_q, bdrop_d;
  logic [7:0]          fdrop_q, fdrop_d;

  logic                accept;
  logic                busy_drop;
  logic                write_ok;
  logic                write_drop;
  logic                gap_push;
  logic                do_pop;
  logic                overwrite;
  logic [REC_W-1:0]    rec;

`ifdef BFA_TIMESTAMP_EN
  logic [STAMP_W-1:0]  stamp_lat_q, stamp_lat_d;
  logic [STAMP_W-1:0]  frame_stamp_q, frame_stamp_d;
`else
  logic                unused_stamp;
  assign unused_stamp = ^stamp_i;
`endif

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [1:0] n);
    logic [8:0] s;
    s = {1'b0, v} + {7'd0, n};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  always_comb begin
    state_d    = state_q;
    data_lat_d = data_lat_q;
    par_lat_d  = par_lat_q;
    stop_lat_d = stop_lat_q;
    par_ok_d   = par_ok_q;
    stop_ok_d  = stop_ok_q;
    data_d     = data_q;
    accept     = 1'b0;
    write_ok   = 1'b0;
    write_drop = 1'b0;
`ifdef BFA_TIMESTAMP_EN
    stamp_lat_d = stamp_lat_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (byte_valid_i) begin
          accept     = 1'b1;
          data_lat_d = data_i;
          par_lat_d  = parity_bit_i;
          stop_lat_d = stop_bit_i;
`ifdef BFA_TIMESTAMP_EN
          stamp_lat_d = stamp_i;
`endif
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        par_ok_d  = !cfg_parity_en_i || (par_lat_q == ((^data_lat_q) ^ cfg_parity_odd_i));
        stop_ok_d = stop_lat_q;
        data_d    = cfg_msb_first_i ? bit_rev(data_lat_q) : data_lat_q;
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        state_d = S_IDLE;
        if (par_ok_q && stop_ok_q) begin
          write_ok   = !p_full_i && !rst;
          write_drop = p_full_i;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_drop = byte_valid_i && (state_q != S_IDLE);

    perr_d  = sat_inc(perr_q, {1'b0, (state_q == S_WRITE) && !par_ok_q});
    serr_d  = sat_inc(serr_q, {1'b0, (state_q == S_WRITE) && par_ok_q && !stop_ok_q});
    bdrop_d = sat_inc(bdrop_q, {1'b0, busy_drop} + {1'b0, write_drop});

    // Idle gap is measured from the last accepted character, not from the last written byte.
    gap_d    = gap_q;
    gap_push = 1'b0;
    if (accept) begin
      gap_d = '0;
    end else if (baud_tick_i && (gap_q != GAP_MAX)) begin
      gap_d    = gap_q + 8'd1;
      gap_push = frame_open_q && (gap_d == GAP_MAX);
    end

`ifdef BFA_TIMESTAMP_EN
    rec           = {frame_stamp_q, frame_cnt_q};
    frame_stamp_d = frame_stamp_q;
`else
    rec           = {{STAMP_W{1'b0}}, frame_cnt_q};
`endif

    // A gap push closes the old frame first, so a byte written in the same cycle opens a new one.
    frame_open_d = frame_open_q && !gap_push;
    frame_cnt_d  = frame_cnt_q;
    if (write_ok) begin
      if (frame_open_d) begin
        if (frame_cnt_q != CNT_MAX) frame_cnt_d = frame_cnt_q + 1'b1;
      end else begin
        frame_open_d = 1'b1;
        frame_cnt_d  = CNT_W'(1);
`ifdef BFA_TIMESTAMP_EN
        frame_stamp_d = stamp_lat_q;
`endif
      end
    end

    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    level_d   = level_q;
    do_pop    = frame_rd_i && (level_q != '0);
    overwrite = gap_push && !do_pop && (level_q == LVL_FULL);
    if (gap_push) begin
      mem_d[wr_ptr_q] = rec;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop || overwrite) rd_ptr_d = rd_ptr_q + 1'b1;
    if (gap_push && !do_pop && !overwrite) begin
      level_d = level_q + 1'b1;
    end else if (do_pop && !gap_push) begin
      level_d = level_q - 1'b1;
    end
    fdrop_d = sat_inc(fdrop_q, {1'b0, overwrite});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      data_lat_q   <= '0;
      par_lat_q    <= 1'b0;
      stop_lat_q   <= 1'b0;
      par_ok_q     <= 1'b0;
      stop_ok_q    <= 1'b0;
      data_q       <= '0;
      gap_q        <= GAP_MAX;
      frame_open_q <= 1'b0;
      frame_cnt_q  <= '0;
      for (int i = 0; i < FRAME_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      level_q      <= '0;
      perr_q       <= '0;
      serr_q       <= '0;
      bdrop_q      <= '0;
      fdrop_q      <= '0;
`ifdef BFA_TIMESTAMP_EN
      stamp_lat_q   <= '0;
      frame_stamp_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      data_lat_q   <= data_lat_d;
      par_lat_q    <= par_lat_d;
      stop_lat_q   <= stop_lat_d;
      par_ok_q     <= par_ok_d;
      stop_ok_q    <= stop_ok_d;
      data_q       <= data_d;
      gap_q        <= gap_d;
      frame_open_q <= frame_open_d;
      frame_cnt_q  <= frame_cnt_d;
      mem_q        <= mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      level_q      <= level_d;
      perr_q       <= perr_d;
      serr_q       <= serr_d;
      bdrop_q      <= bdrop_d;
      fdrop_q      <= fdrop_d;
`ifdef BFA_TIMESTAMP_EN
      stamp_lat_q   <= stamp_lat_d;
      frame_stamp_q <= frame_stamp_d;
`endif
    end
  end

  assign n_we_o           = ~write_ok;
  assign data_o           = data_q;
  assign frame_valid_o    = (level_q != '0);
  assign frame_info_o     = frame_valid_o ? mem_q[rd_ptr_q] : '0;
  assign frame_level_o    = level_q;
  assign parity_err_cnt_o = perr_q;
  assign stop_err_cnt_o   = serr_q;
  assign byte_drop_cnt_o  = bdrop_q;
  assign frame_drop_cnt_o = fdrop_q;

endmodule

// File: tb/tb_byte_frame_analyser.sv
// Randomised and directed bench for byte_frame_analyser against a cycle-timed behavioural model.
// Stamp expectations follow BFA_TIMESTAMP_EN when it is defined for the build.
module tb_byte_frame_analyser;

  localparam int DATA_W      = 8;
  localparam int FRAME_DEPTH = 4;
  localparam int CNT_W       = 12;
  localparam int STAMP_W     = 16;
  localparam int GAP_BAUDS   = 28;
  localparam int REC_W       = STAMP_W + CNT_W;
  localparam int LVL_W       = $clog2(FRAME_DEPTH) + 1;

`ifdef BFA_TIMESTAMP_EN
  localparam bit STAMP_ON = 1'b1;
`else
  localparam bit STAMP_ON = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 byte_valid = 1'b0;
  logic [DATA_W-1:0]    data = '0;
  logic                 parity_bit = 1'b0;
  logic                 stop_bit = 1'b1;
  logic                 baud_tick = 1'b0;
  logic [STAMP_W-1:0]   stamp = '0;
  logic                 cfg_parity_en = 1'b1;
  logic                 cfg_parity_odd = 1'b0;
  logic                 cfg_msb_first = 1'b0;
  logic                 p_full = 1'b0;
  logic                 frame_rd = 1'b0;

  logic                 n_we_o;
  logic [DATA_W-1:0]    data_o;
  logic                 frame_valid_o;
  logic [REC_W-1:0]     frame_info_o;
  logic [LVL_W-1:0]     frame_level_o;
  logic [7:0]           parity_err_cnt_o, stop_err_cnt_o, byte_drop_cnt_o, frame_drop_cnt_o;

  always #5 clk = ~clk;

  byte_frame_analyser #(
    .DATA_W(DATA_W), .FRAME_DEPTH(FRAME_DEPTH), .CNT_W(CNT_W),
    .STAMP_W(STAMP_W), .GAP_BAUDS(GAP_BAUDS)
  ) dut (
    .clk(clk), .rst(rst), .byte_valid_i(byte_valid), .data_i(data),
    .parity_bit_i(parity_bit), .stop_bit_i(stop_bit), .baud_tick_i(baud_tick),
    .stamp_i(stamp), .cfg_parity_en_i(cfg_parity_en), .cfg_parity_odd_i(cfg_parity_odd),
    .cfg_msb_first_i(cfg_msb_first), .n_we_o(n_we_o), .data_o(data_o), .p_full_i(p_full),
    .frame_rd_i(frame_rd), .frame_valid_o(frame_valid_o), .frame_info_o(frame_info_o),
    .frame_level_o(frame_level_o), .parity_err_cnt_o(parity_err_cnt_o),
    .stop_err_cnt_o(stop_err_cnt_o), .byte_drop_cnt_o(byte_drop_cnt_o),
    .frame_drop_cnt_o(frame_drop_cnt_o)
  );

  int     n_checks = 0;
  int     n_errors = 0;
  longint cyc = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [STAMP_W-1:0] stampField(input logic [STAMP_W-1:0] s);
    return STAMP_ON ? s : '0;
  endfunction

  function automatic logic [7:0] sat8(input int v);
    return (v > 255) ? 8'd255 : 8'(v);
  endfunction

  // Reference model: a character accepted in cycle c is judged in c+1 and written in c+2,
  // and the analyser is deaf to new characters until c+3.
  logic [REC_W-1:0]   m_q[$];
  logic               m_pend = 1'b0;
  longint             m_pend_cyc = 0;
  longint             m_free = 0;
  logic [DATA_W-1:0]  m_pdata = '0;
  logic [DATA_W-1:0]  m_rev;
  logic               m_ppar = 1'b0, m_pstop = 1'b0;
  logic [STAMP_W-1:0] m_pstamp = '0;
  logic               m_par_ok = 1'b0, m_stop_ok = 1'b0;
  logic [DATA_W-1:0]  m_data = '0;
  int                 m_gap = GAP_BAUDS;
  logic               m_open = 1'b0;
  int                 m_cnt = 0;
  logic [STAMP_W-1:0] m_fstamp = '0;
  int                 m_perr = 0, m_serr = 0, m_bdrop = 0, m_fdrop = 0;

  always @(posedge clk) begin
    logic             written;
    logic             closing;
    logic             accepted;
    logic [REC_W-1:0] rec;
    written  = 1'b0;
    closing  = 1'b0;
    accepted = 1'b0;
    rec      = '0;
    if (rst) begin
      m_q.delete();
      m_pend = 1'b0;  m_free = 0;  m_data = '0;
      m_gap = GAP_BAUDS;  m_open = 1'b0;  m_cnt = 0;  m_fstamp = '0;
      m_perr = 0;  m_serr = 0;  m_bdrop = 0;  m_fdrop = 0;
    end else begin
      if (m_pend && cyc == m_pend_cyc + 1) begin
        m_par_ok  = !cfg_parity_en || (m_ppar == ((^m_pdata) ^ cfg_parity_odd));
        m_stop_ok = m_pstop;
        m_rev     = {<<{m_pdata}};
        m_data    = cfg_msb_first ? m_rev : m_pdata;
      end
      if (m_pend && cyc == m_pend_cyc + 2) begin
        m_pend = 1'b0;
        if (!m_par_ok)       m_perr++;
        else if (!m_stop_ok) m_serr++;
        else if (p_full)     m_bdrop++;
        else                 written = 1'b1;
      end
      if (byte_valid) begin
        if (cyc >= m_free) begin
          accepted   = 1'b1;
          m_pend     = 1'b1;
          m_pend_cyc = cyc;
          m_free     = cyc + 3;
          m_pdata    = data;
          m_ppar     = parity_bit;
          m_pstop    = stop_bit;
          m_pstamp   = stamp;
        end else begin
          m_bdrop++;
        end
      end
      if (accepted) begin
        m_gap = 0;
      end else if (baud_tick && m_gap < GAP_BAUDS) begin
        m_gap++;
        if (m_gap == GAP_BAUDS && m_open) begin
          closing = 1'b1;
          rec     = {m_fstamp, CNT_W'(m_cnt)};
          m_open  = 1'b0;
        end
      end
      if (written) begin
        if (m_open) begin
          if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end else begin
          m_open   = 1'b1;
          m_cnt    = 1;
          m_fstamp = stampField(m_pstamp);
        end
      end
      if (frame_rd && m_q.size() > 0) void'(m_q.pop_front());
      if (closing) begin
        if (m_q.size() == FRAME_DEPTH) begin
          void'(m_q.pop_front());
          m_fdrop++;
        end
        m_q.push_back(rec);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    logic exp_we;
    exp_we = !(m_pend && cyc == m_pend_cyc + 2 && m_par_ok && m_stop_ok && !p_full && !rst);
    checkOutput("n_we_o", n_we_o, exp_we);
    checkOutput("data_o", data_o, m_data);
    checkOutput("frame_valid_o", frame_valid_o, m_q.size() > 0);
    checkOutput("frame_info_o", frame_info_o, (m_q.size() > 0) ? m_q[0] : '0);
    checkOutput("frame_level_o", frame_level_o, m_q.size());
    checkOutput("parity_err_cnt_o", parity_err_cnt_o, sat8(m_perr));
    checkOutput("stop_err_cnt_o", stop_err_cnt_o, sat8(m_serr));
    checkOutput("byte_drop_cnt_o", byte_drop_cnt_o, sat8(m_bdrop));
    checkOutput("frame_drop_cnt_o", frame_drop_cnt_o, sat8(m_fdrop));
  end

  task automatic applyStimulus(input logic bv, input logic [DATA_W-1:0] d, input logic par,
                               input logic stp, input logic tick, input logic full,
                               input logic rd, input logic r);
    @(posedge clk);
    #2;
    byte_valid = bv;  data = d;  parity_bit = par;  stop_bit = stp;
    baud_tick = tick;  p_full = full;  frame_rd = rd;  rst = r;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idleTicks(input int n);
    repeat (n) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic sendGood(input logic [DATA_W-1:0] d);
    applyStimulus(1'b1, d, ^d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic popOnce();
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset n_we_o", n_we_o, 1'b1);
    checkOutput("reset data_o", data_o, 8'h00);
    checkOutput("reset frame_valid_o", frame_valid_o, 1'b0);
    checkOutput("reset frame_info_o", frame_info_o, 28'h0);
    checkOutput("reset frame_level_o", frame_level_o, 3'd0);

    // Even parity, LSB-first, then the same character bit-reversed.
    applyStimulus(1'b1, 8'h35, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    @(negedge clk);
    checkOutput("lit n_we_o cycle1", n_we_o, 1'b1);
    idle(1);
    @(negedge clk);
    checkOutput("lit n_we_o cycle2", n_we_o, 1'b0);
    checkOutput("lit data_o lsb", data_o, 8'h35);
    idle(1);
    cfg_msb_first = 1'b1;
    applyStimulus(1'b1, 8'h35, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    @(negedge clk);
    checkOutput("lit n_we_o msb", n_we_o, 1'b0);
    checkOutput("lit data_o msb", data_o, 8'hAC);
    idle(1);
    cfg_msb_first = 1'b0;

    // Three bytes 11 ticks apart close into one record after 28 idle ticks.
    doReset();
    stamp = 16'h1234;
    sendGood(8'h11);
    idle(1);
    stamp = 16'h4321;
    idleTicks(11);
    sendGood(8'h22);
    idleTicks(11);
    sendGood(8'h33);
    idle(2);
    idleTicks(27);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("lit frame_valid_o at 28th tick", frame_valid_o, 1'b0);
    idle(1);
    @(negedge clk);
    checkOutput("lit frame_valid_o after gap", frame_valid_o, 1'b1);
    checkOutput("lit frame_info_o 3 bytes", frame_info_o, {stampField(16'h1234), 12'd3});

    // Parity error between two good bytes leaves a 2-byte frame.
    stamp = 16'h0BEE;
    sendGood(8'h44);
    idle(1);
    stamp = 16'h7777;
    idle(2);
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    @(negedge clk);
    checkOutput("lit n_we_o parity error", n_we_o, 1'b1);
    idle(1);
    sendGood(8'h55);
    idle(3);
    @(negedge clk);
    checkOutput("lit parity_err_cnt_o", parity_err_cnt_o, 8'd1);
    idleTicks(28);
    @(negedge clk);
    checkOutput("lit frame_level_o two", frame_level_o, 3'd2);
    popOnce();
    idle(1);
    @(negedge clk);
    checkOutput("lit frame_info_o 2 bytes", frame_info_o, {stampField(16'h0BEE), 12'd2});

    // Byte FIFO full: the good byte is dropped and opens no frame.
    doReset();
    applyStimulus(1'b1, 8'h35, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("lit n_we_o p_full", n_we_o, 1'b1);
    idle(1);
    @(negedge clk);
    checkOutput("lit byte_drop_cnt_o", byte_drop_cnt_o, 8'd1);
    idleTicks(28);
    @(negedge clk);
    checkOutput("lit no frame after drop", frame_valid_o, 1'b0);

    // Five frames of 1..5 bytes into a 4-deep FIFO: the oldest is discarded.
    doReset();
    for (int f = 1; f <= 5; f++) begin
      for (int b = 1; b <= f; b++) begin
        sendGood(8'(f * 16 + b));
        idle(3);
      end
      idleTicks(28);
    end
    @(negedge clk);
    checkOutput("lit frame_level_o full", frame_level_o, 3'd4);
    checkOutput("lit frame_drop_cnt_o", frame_drop_cnt_o, 8'd1);
    checkOutput("lit head is frame 2", frame_info_o[CNT_W-1:0], 12'd2);
    repeat (4) popOnce();
    idle(1);
    @(negedge clk);
    checkOutput("lit empty after 4 pops", frame_valid_o, 1'b0);
    popOnce();
    idle(1);
    @(negedge clk);
    checkOutput("lit level after 5th pop", frame_level_o, 3'd0);

    // Reset during CHECK of a good byte with a frame open.
    doReset();
    sendGood(8'h5A);
    idle(3);
    sendGood(8'hA5);
    doReset();
    idle(1);
    @(negedge clk);
    checkOutput("lit n_we_o after mid reset", n_we_o, 1'b1);
    checkOutput("lit data_o after mid reset", data_o, 8'h00);
    checkOutput("lit level after mid reset", frame_level_o, 3'd0);
    idleTicks(28);
    @(negedge clk);
    checkOutput("lit no record after mid reset", frame_valid_o, 1'b0);

    // Random traffic alternating dense bursts and quiet stretches so frames close.
    for (int i = 0; i < 4000; i++) begin
      logic tk, bv, par, stp, full, rd, r, quiet;
      logic [DATA_W-1:0] d;
      quiet = ((i / 300) % 2) == 1;
      tk    = ($urandom_range(2) == 0);
      bv    = !tk && (quiet ? ($urandom_range(149) == 0) : ($urandom_range(3) == 0));
      d     = DATA_W'($urandom);
      par   = ($urandom_range(4) == 0) ? 1'($urandom) : ((^d) ^ cfg_parity_odd);
      stp   = ($urandom_range(9) != 0);
      full  = ($urandom_range(7) == 0);
      rd    = ($urandom_range(11) == 0);
      r     = ($urandom_range(999) == 0);
      applyStimulus(bv, d, par, stp, tk, full, rd, r);
      stamp = STAMP_W'($urandom);
      if (i % 50 == 0) begin
        cfg_parity_en  = ($urandom_range(3) != 0);
        cfg_parity_odd = 1'($urandom);
        cfg_msb_first  = 1'($urandom);
      end
    end
    idle(5);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
